// File: rtl/reg_file.sv
// rtl/reg_file.sv - renaming architectural register file with ROB commit and decoder issue ports
//
// Purpose:
//   Holds per-register data, busy flag and producer tag (PC of the youngest
//   in-flight writer). The decoder renames a destination by marking it busy
//   with its PC. The ROB commit always writes data, but it only clears busy
//   when the committing PC is still the recorded producer. An exception
//   clears every busy bit.
//
// Optional feature macro: REG_FILE_COMMIT_BYPASS_EN
//   When this macro is defined, the read ports forward a current-cycle commit
//   that would clear busy. The forwarded result is data = commit data and
//   busy = 0. When it is undefined, the read ports show registered state only.
//
// Ports:
//   clk                   clock, all state updates on the rising edge
//   rst                   synchronous active-high reset (overrides everything)
//   rdy                   global enable, low freezes all state
//   is_commit_from_rob    commit valid
//   commit_rd_from_rob    commit destination index
//   commit_pc_from_rob    commit PC (compared against the stored tag)
//   commit_data_from_rob  commit result data
//   is_exception_from_rob flush: clear all busy bits, drop same-cycle issue
//   is_empty_from_dc      low = rename request valid
//   rd_from_dc            rename destination index
//   pc_from_dc            rename PC (becomes the new tag)
//   rs1_from_dc/rs2_from_dc               source indices
//   rs1/rs2_data_to_rs, _tag_to_rs, _busy_to_rs  combinational read results

module reg_file #(
   parameter int RegCount = 32,
   parameter int RdLength = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rdy,
   input  logic                is_commit_from_rob,
   input  logic [RdLength:0]   commit_rd_from_rob,
   input  logic [31:0]         commit_pc_from_rob,
   input  logic [31:0]         commit_data_from_rob,
   input  logic                is_exception_from_rob,
   input  logic                is_empty_from_dc,
   input  logic [RdLength:0]   rd_from_dc,
   input  logic [31:0]         pc_from_dc,
   input  logic [RdLength:0]   rs1_from_dc,
   input  logic [RdLength:0]   rs2_from_dc,
   output logic [31:0]         rs1_data_to_rs,
   output logic [31:0]         rs2_data_to_rs,
   output logic [31:0]         rs1_tag_to_rs,
   output logic [31:0]         rs2_tag_to_rs,
   output logic                rs1_busy_to_rs,
   output logic                rs2_busy_to_rs
);

   localparam int IdxW = RdLength + 1;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] tag;
      logic        busy;
   } rd_port_t;

   logic [31:0]         r_data [RegCount];
   logic [31:0]         r_tag  [RegCount];
   logic [RegCount-1:0] r_busy;

   logic     w_commit;
   logic     w_issue;
   rd_port_t w_rs1;
   rd_port_t w_rs2;

   assign w_commit = is_commit_from_rob && (commit_rd_from_rob != '0);
   // An exception squashes the rename that arrives in the same cycle.
   assign w_issue  = !is_empty_from_dc && (rd_from_dc != '0) && !is_exception_from_rob;

   // Entry 0 is written only by reset, so it stays zero permanently.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RegCount; i++) begin
            r_data[i] <= '0;
            r_tag[i]  <= '0;
            r_busy[i] <= 1'b0;
         end
      end else if (rdy) begin
         for (int i = 1; i < RegCount; i++) begin
            if (w_commit && (commit_rd_from_rob == IdxW'(i))) begin
               r_data[i] <= commit_data_from_rob;
               // A mismatched tag means a younger rename owns the register.
               if (r_busy[i] && (r_tag[i] == commit_pc_from_rob)) begin
                  r_busy[i] <= 1'b0;
               end
            end
            // Later assignments win: flush beats commit, and issue beats commit.
            if (is_exception_from_rob) begin
               r_busy[i] <= 1'b0;
            end else if (w_issue && (rd_from_dc == IdxW'(i))) begin
               r_busy[i] <= 1'b1;
               r_tag[i]  <= pc_from_dc;
            end
         end
      end
   end

   function automatic rd_port_t read_port(input logic [IdxW-1:0] idx);
      rd_port_t r;
      r = '0;
      for (int i = 0; i < RegCount; i++) begin
         if (idx == IdxW'(i)) begin
            r.data = r_data[i];
            r.tag  = r_tag[i];
            r.busy = r_busy[i];
         end
      end
`ifdef REG_FILE_COMMIT_BYPASS_EN
      if (is_commit_from_rob && rdy && (idx != '0) && (idx == commit_rd_from_rob) &&
          r.busy && (r.tag == commit_pc_from_rob)) begin
         r.data = commit_data_from_rob;
         r.busy = 1'b0;
      end
`endif
      return r;
   endfunction

   always_comb begin
      w_rs1 = read_port(rs1_from_dc);
   end

   always_comb begin
      w_rs2 = read_port(rs2_from_dc);
   end

   assign rs1_data_to_rs = w_rs1.data;
   assign rs1_tag_to_rs  = w_rs1.tag;
   assign rs1_busy_to_rs = w_rs1.busy;
   assign rs2_data_to_rs = w_rs2.data;
   assign rs2_tag_to_rs  = w_rs2.tag;
   assign rs2_busy_to_rs = w_rs2.busy;

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - self-checking bench for reg_file: directed vector table plus randomized model check

module tb_reg_file;

   localparam int RC = 32;
   localparam int RL = 4;
`ifdef REG_FILE_COMMIT_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, rdy, cm, exc, emp;
   logic [4:0]  crd, rd, rs1, rs2;
   logic [31:0] cpc, cdata, pc;
   logic [31:0] rs1_data, rs2_data, rs1_tag, rs2_tag;
   logic        rs1_busy, rs2_busy;

   always #5 clk = ~clk;

   reg_file #(.RegCount(RC), .RdLength(RL)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .is_commit_from_rob(cm), .commit_rd_from_rob(crd),
      .commit_pc_from_rob(cpc), .commit_data_from_rob(cdata),
      .is_exception_from_rob(exc),
      .is_empty_from_dc(emp), .rd_from_dc(rd), .pc_from_dc(pc),
      .rs1_from_dc(rs1), .rs2_from_dc(rs2),
      .rs1_data_to_rs(rs1_data), .rs2_data_to_rs(rs2_data),
      .rs1_tag_to_rs(rs1_tag), .rs2_tag_to_rs(rs2_tag),
      .rs1_busy_to_rs(rs1_busy), .rs2_busy_to_rs(rs2_busy)
   );

   // Expected read value packed as {data, tag, busy}.
   typedef struct {
      logic        rst, rdy, cm;
      logic [4:0]  crd;
      logic [31:0] cpc, cdata;
      logic        exc, emp;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [4:0]  rs1, rs2;
      logic        chk;
      logic [64:0] e1, e2;
      string       name;
   } vec_t;

   int errors = 0;
   int checks = 0;

   // Reference state: plain arrays indexed by architectural register.
   logic [31:0] m_data [RC];
   logic [31:0] m_tag  [RC];
   logic        m_busy [RC];

   function automatic logic [64:0] E(input logic [31:0] d, input logic [31:0] t, input logic b);
      return {d, t, b};
   endfunction

   function automatic vec_t V(input string name, input logic r, input logic y,
                              input logic c, input logic [4:0] cr, input logic [31:0] cp,
                              input logic [31:0] cd, input logic x, input logic e,
                              input logic [4:0] d, input logic [31:0] p,
                              input logic [4:0] a, input logic [4:0] b,
                              input logic k, input logic [64:0] e1, input logic [64:0] e2);
      vec_t v;
      v.name = name; v.rst = r; v.rdy = y; v.cm = c; v.crd = cr; v.cpc = cp; v.cdata = cd;
      v.exc = x; v.emp = e; v.rd = d; v.pc = p; v.rs1 = a; v.rs2 = b; v.chk = k;
      v.e1 = e1; v.e2 = e2;
      return v;
   endfunction

   function automatic vec_t IDLE(input string name, input logic [4:0] a, input logic [4:0] b,
                                 input logic [64:0] e1, input logic [64:0] e2);
      return V(name, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, a, b, 1, e1, e2);
   endfunction

   function automatic vec_t ISSUE(input string name, input logic [4:0] d, input logic [31:0] p,
                                  input logic [4:0] a, input logic [4:0] b,
                                  input logic [64:0] e1, input logic [64:0] e2);
      return V(name, 0, 1, 0, 0, 0, 0, 0, 0, d, p, a, b, 1, e1, e2);
   endfunction

   task automatic drive(input vec_t v);
      rst = v.rst; rdy = v.rdy; cm = v.cm; crd = v.crd; cpc = v.cpc; cdata = v.cdata;
      exc = v.exc; emp = v.emp; rd = v.rd; pc = v.pc; rs1 = v.rs1; rs2 = v.rs2;
   endtask

   task automatic compare(input string name, input logic [64:0] e1, input logic [64:0] e2);
      logic [64:0] a1, a2;
      a1 = {rs1_data, rs1_tag, rs1_busy};
      a2 = {rs2_data, rs2_tag, rs2_busy};
      checks++;
      if (a1 !== e1) begin
         errors++;
         $display("FAIL %s rs1: got data=%h tag=%h busy=%b want data=%h tag=%h busy=%b",
                  name, a1[64:33], a1[32:1], a1[0], e1[64:33], e1[32:1], e1[0]);
      end
      checks++;
      if (a2 !== e2) begin
         errors++;
         $display("FAIL %s rs2: got data=%h tag=%h busy=%b want data=%h tag=%h busy=%b",
                  name, a2[64:33], a2[32:1], a2[0], e2[64:33], e2[32:1], e2[0]);
      end
   endtask

   // Expected read from the model, including the same-cycle commit forwarding.
   function automatic logic [64:0] model_read(input logic [4:0] idx, input vec_t v);
      logic [64:0] r;
      if (idx == 0) return '0;
      r = {m_data[idx], m_tag[idx], m_busy[idx]};
      if (BYP && v.cm && v.rdy && idx == v.crd && m_busy[idx] && m_tag[idx] == v.cpc)
         r = {v.cdata, m_tag[idx], 1'b0};
      return r;
   endfunction

   // One clock of architectural behaviour.
   task automatic model_step(input vec_t v);
      if (v.rst) begin
         for (int i = 0; i < RC; i++) begin
            m_data[i] = 0; m_tag[i] = 0; m_busy[i] = 0;
         end
      end else if (v.rdy) begin
         if (v.cm && v.crd != 0) begin
            m_data[v.crd] = v.cdata;
            if (m_busy[v.crd] && m_tag[v.crd] == v.cpc) m_busy[v.crd] = 0;
         end
         if (v.exc) begin
            for (int i = 0; i < RC; i++) m_busy[i] = 0;
         end else if (!v.emp && v.rd != 0) begin
            m_busy[v.rd] = 1;
            m_tag[v.rd]  = v.pc;
         end
      end
   endtask

   vec_t tbl[$];
   localparam logic [64:0] Z = 65'd0;

   initial begin
      vec_t v;
      drive(V("init", 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, Z, Z));
      @(posedge clk); #1;

      tbl.push_back(V("reset", 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 5, 0, 0, Z, Z));
      tbl.push_back(IDLE("after_reset", 5, 0, Z, Z));
      tbl.push_back(ISSUE("issue3", 3, 32'h100, 3, 0, Z, Z));
      tbl.push_back(IDLE("busy3", 3, 0, E(0, 32'h100, 1), Z));
      tbl.push_back(V("commit3", 0, 1, 1, 3, 32'h100, 32'hDEAD, 0, 1, 0, 0, 5, 0, 1, Z, Z));
      tbl.push_back(IDLE("done3", 3, 0, E(32'hDEAD, 32'h100, 0), Z));
      tbl.push_back(ISSUE("issue4a", 4, 32'h200, 4, 0, Z, Z));
      tbl.push_back(ISSUE("issue4b", 4, 32'h204, 4, 0, E(0, 32'h200, 1), Z));
      tbl.push_back(V("commit4old", 0, 1, 1, 4, 32'h200, 7, 0, 1, 0, 0, 4, 0, 1,
                      E(0, 32'h204, 1), Z));
      tbl.push_back(IDLE("reg4", 4, 0, E(7, 32'h204, 1), Z));
      tbl.push_back(V("cm_iss6", 0, 1, 1, 6, 32'h300, 9, 0, 0, 6, 32'h310, 0, 6, 1, Z, Z));
      tbl.push_back(IDLE("reg6", 0, 6, Z, E(9, 32'h310, 1)));
      tbl.push_back(ISSUE("ren1", 1, 32'h500, 0, 0, Z, Z));
      tbl.push_back(ISSUE("ren2", 2, 32'h504, 0, 0, Z, Z));
      tbl.push_back(ISSUE("ren3", 3, 32'h508, 0, 0, Z, Z));
      tbl.push_back(V("exc", 0, 1, 1, 1, 32'h500, 32'h44, 1, 0, 5, 32'h50C, 1, 2, 1,
                      BYP ? E(32'h44, 32'h500, 0) : E(0, 32'h500, 1), E(0, 32'h504, 1)));
      tbl.push_back(IDLE("post_exc_a", 1, 5, E(32'h44, 32'h500, 0), Z));
      tbl.push_back(IDLE("post_exc_b", 2, 3, E(0, 32'h504, 0), E(32'hDEAD, 32'h508, 0)));
      tbl.push_back(ISSUE("issue7", 7, 32'h400, 0, 7, Z, Z));
      tbl.push_back(V("commit7", 0, 1, 1, 7, 32'h400, 32'h55, 0, 1, 0, 0, 0, 7, 1,
                      Z, BYP ? E(32'h55, 32'h400, 0) : E(0, 32'h400, 1)));
      tbl.push_back(IDLE("reg7", 0, 7, Z, E(32'h55, 32'h400, 0)));
      tbl.push_back(V("rdy_low", 0, 0, 1, 7, 0, 32'h99, 0, 0, 8, 32'h600, 7, 8, 1,
                      E(32'h55, 32'h400, 0), Z));
      tbl.push_back(IDLE("frozen", 7, 8, E(32'h55, 32'h400, 0), Z));
      tbl.push_back(V("zero_wr", 0, 1, 1, 0, 0, 32'h123, 0, 0, 0, 32'h700, 0, 0, 1, Z, Z));
      tbl.push_back(IDLE("zero_rd", 0, 0, Z, Z));
      tbl.push_back(ISSUE("issue9", 9, 32'h700, 9, 0, Z, Z));
      tbl.push_back(V("rst_mid", 1, 0, 0, 0, 0, 0, 0, 0, 10, 32'h704, 9, 0, 1,
                      E(0, 32'h700, 1), Z));
      tbl.push_back(IDLE("rst_clean", 9, 3, Z, Z));
      tbl.push_back(IDLE("rst_clean2", 7, 10, Z, Z));

      foreach (tbl[k]) begin
         drive(tbl[k]);
         #2;
         if (tbl[k].chk) compare(tbl[k].name, tbl[k].e1, tbl[k].e2);
         @(posedge clk); #1;
      end

      // Randomized phase against the reference model, starting from reset.
      v = V("rand_rst", 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, Z, Z);
      drive(v);
      model_step(v);
      @(posedge clk); #1;

      for (int n = 0; n < 600; n++) begin
         v.name  = "rand";
         v.rst   = ($urandom_range(0, 63) == 0);
         v.rdy   = ($urandom_range(0, 7) != 0);
         v.cm    = $urandom_range(0, 1);
         v.crd   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         v.cpc   = ($urandom_range(0, 1) == 1) ? m_tag[v.crd] : {24'd0, 8'($urandom_range(0, 15))};
         v.cdata = $urandom;
         v.exc   = ($urandom_range(0, 15) == 0);
         v.emp   = ($urandom_range(0, 2) == 0);
         v.rd    = 5'($urandom_range(0, 7));
         v.pc    = {24'd0, 8'($urandom_range(0, 15))};
         v.rs1   = ($urandom_range(0, 1) == 1) ? v.crd : 5'($urandom_range(0, 7));
         v.rs2   = 5'($urandom_range(0, 31));
         v.chk   = 1;
         v.e1    = model_read(v.rs1, v);
         v.e2    = model_read(v.rs2, v);
         drive(v);
         #2;
         compare(v.name, v.e1, v.e2);
         model_step(v);
         @(posedge clk); #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter RegCount, default 32, number of architectural registers.
REQ-002 SHALL have parameter RdLength, default 4, register index MSB (index width RdLength+1).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rdy  input  1  global enable; low freezes all state.
REQ-006 SHALL have ports is_commit_from_rob  input  1, commit_rd_from_rob  input  RdLength+1, commit_pc_from_rob  input  32, commit_data_from_rob  input  32, all carrying the ROB commit broadcast.
REQ-007 SHALL have port is_exception_from_rob  input  1  mispredict flush, asserted in the same cycle as the offending commit.
REQ-008 SHALL have ports is_empty_from_dc  input  1 (low = issue valid), rd_from_dc  input  RdLength+1, pc_from_dc  input  32  rename request.
REQ-009 SHALL have ports rs1_from_dc, rs2_from_dc  input  RdLength+1  source indices.
REQ-010 SHALL have ports rs1_data_to_rs, rs2_data_to_rs  output  32; rs1_tag_to_rs, rs2_tag_to_rs  output  32 (producer PC); rs1_busy_to_rs, rs2_busy_to_rs  output  1.

Function
REQ-011 SHALL hold per register: data (32b), busy (1b), tag (32b producer PC).
REQ-012 Read ports SHALL be combinational: data/tag/busy of the indexed register, subject to REQ-019.
REQ-013 Register 0 SHALL always read data 0, busy 0, tag 0; writes and renames to index 0 ignored.
REQ-014 Commit (is_commit_from_rob high, rd != 0): data[rd] <= commit_data_from_rob next edge, unconditionally.
REQ-015 Commit SHALL clear busy[rd] only if busy[rd]=1 and tag[rd]==commit_pc_from_rob; otherwise busy/tag unchanged (younger rename pending).
REQ-016 Issue (is_empty_from_dc low, rd != 0, no exception): busy[rd] <= 1, tag[rd] <= pc_from_dc.
REQ-017 Commit and issue to same rd in one cycle: data written per REQ-014; issue wins busy/tag (busy=1, tag=new pc).
REQ-018 Exception cycle: commit of that cycle still writes data per REQ-014; all busy bits cleared; issue in that cycle ignored; tags retain values.
REQ-019 Same-cycle read of a register whose busy would be cleared by current commit: behaviour per REQ-027/028.
REQ-020 rdy low: no state change regardless of other inputs; read ports keep reflecting held state.
REQ-021 Single-cycle latency: state written at edge N visible on read ports after edge N.

Reset
REQ-022 rst high at an edge: all data 0, busy 0, tag 0, overriding rdy, commit, issue, exception.
REQ-023 Read outputs SHALL be 0 (data, tag, busy) for every index after reset.
REQ-024 Reset mid-operation (pending renames outstanding) SHALL discard them with no residual busy bits.

Configuration
REQ-025 Feature macro: REG_FILE_COMMIT_BYPASS_EN.
REQ-026 Controls only read-port forwarding of the current-cycle commit.
REQ-027 Defined: if is_commit_from_rob high, rdy high, rs index == commit_rd_from_rob != 0, busy set and tag == commit_pc_from_rob, read port SHALL output data=commit_data_from_rob, busy=0 same cycle.
REQ-028 Undefined: read ports SHALL reflect only registered state; commit visible next cycle.

Verification
REQ-029 Reset, then read rs1=5, rs2=0 -> data 0, busy 0, tag 0 on both.
REQ-030 Issue rd=3 pc=0x100; next cycle read rs1=3 -> busy 1, tag 0x100; commit rd=3 pc=0x100 data=0xDEAD -> after edge busy 0, data 0xDEAD.
REQ-031 Issue rd=4 pc=0x200, then issue rd=4 pc=0x204, commit rd=4 pc=0x200 data=7 -> data 7, busy 1, tag 0x204.
REQ-032 Same cycle: commit rd=6 pc=0x300 data=9 and issue rd=6 pc=0x310 -> data 9, busy 1, tag 0x310.
REQ-033 Rename rd=1,2,3; assert exception with commit rd=1 pc=tag1 data=0x44 plus issue rd=5 -> data[1]=0x44, all busy 0, reg 5 not busy.
REQ-034 With REG_FILE_COMMIT_BYPASS_EN: busy rd=7 tag 0x400, commit pc=0x400 data=0x55 while reading rs2=7 -> same cycle data 0x55, busy 0; without macro -> busy 1 that cycle, 0x55 next cycle.
